// File: rtl/tenkey_scan.sv
// tenkey_scan: 4x3 active-low keypad scanner with frame-based debounce.
// Drives one column low at a time, collects a 12-position frame, classifies
// it (none / single key / multiple keys), debounces on identical frames and
// emits one registered single-cycle code per accepted press.
module tenkey_scan #(
   parameter int SCAN_DIV = 16,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   output logic [2:0] col,
   output logic [9:0] tenkey,
   output logic       close,
   output logic       clear,
   output logic       key_down
);

   localparam int               DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB_MAX  = 4'(DEBOUNCE);

   typedef enum logic [1:0] {CLS_NONE, CLS_KEY, CLS_MULTI} cls_t;
   typedef enum logic {ST_IDLE, ST_HELD} state_t;

   // scan and frame state
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       col_q, col_d;
   logic [11:0]      frame_q, frame_d;
   // debounce state
   cls_t             prev_cls_q, prev_cls_d;
   logic [3:0]       prev_key_q, prev_key_d;
   logic [3:0]       stab_q, stab_d;
   // FSM and registered outputs
   state_t           state_q, state_d;
   logic [9:0]       tenkey_q, tenkey_d;
   logic             close_q, close_d;
   logic             clear_q, clear_d;
   logic             key_down_q, key_down_d;

   logic             sample_now;
   logic             frame_end;
   logic [1:0]       col_idx;
   logic [11:0]      frame_now;
   logic [3:0]       pop_cnt;
   logic [3:0]       key_idx;
   logic [3:0]       key_cmp;
   cls_t             cls_now;

   // Column index of the currently driven strobe
   always_comb begin
      col_idx = 2'd0;
      unique case (col_q)
         3'b110:  col_idx = 2'd0;
         3'b101:  col_idx = 2'd1;
         3'b011:  col_idx = 2'd2;
         default: col_idx = 2'd0;
      endcase
   end

   assign sample_now = (div_q == DIV_LAST);
   assign frame_end  = sample_now && (col_q == 3'b011);

   // Frame view including the rows sampled this cycle; position = row*3 + col
   for (genvar gi = 0; gi < 12; gi++) begin : g_pos
      assign frame_now[gi] = (sample_now && (col_idx == 2'(gi % 3))) ? ~row[gi / 3]
                                                                      : frame_q[gi];
   end

   // Count pressed positions and locate the (single) pressed one
   always_comb begin
      pop_cnt = 4'd0;
      key_idx = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (frame_now[i]) begin
            pop_cnt = pop_cnt + 4'd1;
            key_idx = 4'(i);
         end
      end
      if (pop_cnt == 4'd0) begin
         cls_now = CLS_NONE;
      end else if (pop_cnt == 4'd1) begin
         cls_now = CLS_KEY;
      end else begin
         cls_now = CLS_MULTI;
      end
      // key code only distinguishes frames of class KEY
      key_cmp = (cls_now == CLS_KEY) ? key_idx : 4'd0;
   end

   // Column rotation, frame capture and stability counting
   always_comb begin
      div_d      = div_q + DIV_W'(1);
      col_d      = col_q;
      frame_d    = frame_q;
      prev_cls_d = prev_cls_q;
      prev_key_d = prev_key_q;
      stab_d     = stab_q;
      if (sample_now) begin
         div_d   = '0;
         col_d   = {col_q[1:0], col_q[2]};
         frame_d = frame_now;
      end
      if (frame_end) begin
         if ((cls_now == prev_cls_q) && (key_cmp == prev_key_q)) begin
            stab_d = (stab_q >= DEB_MAX) ? DEB_MAX : stab_q + 4'd1;
         end else begin
            stab_d = 4'd1;
         end
         prev_cls_d = cls_now;
         prev_key_d = key_cmp;
      end
   end

   // Press/release FSM; decides once per frame and emits a one-cycle code
   always_comb begin
      state_d  = state_q;
      tenkey_d = 10'd0;
      close_d  = 1'b0;
      clear_d  = 1'b0;
      if (frame_end) begin
         unique case (state_q)
            ST_IDLE: begin
               if ((cls_now == CLS_KEY) && (stab_d == DEB_MAX)) begin
                  state_d = ST_HELD;
                  unique case (key_idx)
                     4'd9:    close_d  = 1'b1;
                     4'd10:   tenkey_d = 10'b00_0000_0001;
                     4'd11:   clear_d  = 1'b1;
                     default: tenkey_d = 10'b00_0000_0001 << (key_idx + 4'd1);
                  endcase
               end
            end
            ST_HELD: begin
               if ((cls_now == CLS_NONE) && (stab_d == DEB_MAX)) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      key_down_d = (state_d == ST_HELD);
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= '0;
         col_q      <= 3'b110;
         frame_q    <= 12'd0;
         prev_cls_q <= CLS_NONE;
         prev_key_q <= 4'd0;
         stab_q     <= 4'd0;
         state_q    <= ST_IDLE;
         tenkey_q   <= 10'd0;
         close_q    <= 1'b0;
         clear_q    <= 1'b0;
         key_down_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         col_q      <= col_d;
         frame_q    <= frame_d;
         prev_cls_q <= prev_cls_d;
         prev_key_q <= prev_key_d;
         stab_q     <= stab_d;
         state_q    <= state_d;
         tenkey_q   <= tenkey_d;
         close_q    <= close_d;
         clear_q    <= clear_d;
         key_down_q <= key_down_d;
      end
   end

   assign col      = col_q;
   assign tenkey   = tenkey_q;
   assign close    = close_q;
   assign clear    = clear_q;
   assign key_down = key_down_q;

endmodule

// File: tb/tb_tenkey_scan.sv
// tb_tenkey_scan: randomized and directed keypad stimulus, frame-level
// reference model feeding expected pulses / key_down edges into queues,
// and a monitor that compares whatever the DUT presents.
module tb_tenkey_scan;

   localparam int SD   = 4;
   localparam int DB   = 2;
   localparam int FR   = 3 * SD;
   localparam int STAR = 10;
   localparam int HASH = 11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] row;
   logic [2:0] col;
   logic [9:0] tenkey;
   logic       close;
   logic       clear;
   logic       key_down;

   tenkey_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .row      (row),
      .col      (col),
      .tenkey   (tenkey),
      .close    (close),
      .clear    (clear),
      .key_down (key_down)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int cyc;

   // cycles elapsed since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // keypad: keys held while each column is strobed (position = row*3 + col)
   logic [11:0] pad_mask [3];
   int          pad_c;
   always_comb begin
      row   = 4'b1111;
      pad_c = -1;
      case (col)
         3'b110:  pad_c = 0;
         3'b101:  pad_c = 1;
         3'b011:  pad_c = 2;
         default: pad_c = -1;
      endcase
      if (pad_c >= 0) begin
         for (int r = 0; r < 4; r++) row[r] = ~pad_mask[pad_c][r * 3 + pad_c];
      end
   end

   typedef struct { int due; int pos; } pulse_t;
   typedef struct { int due; logic lvl; } kd_t;
   pulse_t exp_pulse [$];
   kd_t    exp_kd [$];

   // frame-level reference state
   int prev_sig = 0;
   int run      = 0;
   bit held     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // expected {clear, close, tenkey} for a keypad position
   function automatic logic [11:0] expect_out(input int pos);
      int sym [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, STAR, 0, HASH};
      if (sym[pos] == STAR) return 12'h400;
      if (sym[pos] == HASH) return 12'h800;
      return 12'h001 << sym[pos];
   endfunction

   task automatic model_reset();
      prev_sig = 0;
      run      = 0;
      held     = 1'b0;
      exp_pulse.delete();
      exp_kd.delete();
   endtask

   // one scan frame; m[c] is what the keypad shows while column c is driven
   task automatic run_frame(input logic [11:0] m0, input logic [11:0] m1, input logic [11:0] m2);
      logic [11:0] m [3];
      logic [11:0] smp;
      int n, k, sig, base;
      base = cyc;
      m[0] = m0; m[1] = m1; m[2] = m2;
      pad_mask[0] = m0; pad_mask[1] = m1; pad_mask[2] = m2;
      smp = 12'd0;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 4; r++)
            smp[r * 3 + c] = m[c][r * 3 + c];
      n = $countones(smp);
      k = 0;
      for (int p = 0; p < 12; p++) if (smp[p]) k = p;
      sig = (n == 0) ? 0 : (n == 1) ? 1 + k : 100;
      run = (sig == prev_sig) ? ((run < DB) ? run + 1 : DB) : 1;
      prev_sig = sig;
      if (!held && n == 1 && run == DB) begin
         held = 1'b1;
         exp_pulse.push_back(pulse_t'{base + FR, k});
         exp_kd.push_back(kd_t'{base + FR, 1'b1});
      end else if (held && n == 0 && run == DB) begin
         held = 1'b0;
         exp_kd.push_back(kd_t'{base + FR, 1'b0});
      end
      repeat (FR) @(negedge clk);
   endtask

   task automatic hold(input logic [11:0] m, input int nf);
      repeat (nf) run_frame(m, m, m);
   endtask

   // monitor: compares scan pattern, pulses and key_down edges each cycle
   logic [11:0] mon_outs;
   logic        prev_pulse = 1'b0;
   logic        prev_kd    = 1'b0;
   logic [2:0]  exp_col;
   pulse_t      mon_p;
   kd_t         mon_k;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_pulse = 1'b0;
         prev_kd    = 1'b0;
      end else begin
         mon_outs = {clear, close, tenkey};
         case ((cyc % FR) / SD)
            0:       exp_col = 3'b110;
            1:       exp_col = 3'b101;
            default: exp_col = 3'b011;
         endcase
         check("col", col, exp_col);
         if (mon_outs != 12'd0) begin
            check("onehot", $countones(mon_outs), 1);
            check("gap", prev_pulse, 1'b0);
            $display("pulse cycle %0d clear=%b close=%b tenkey=%b", cyc, clear, close, tenkey);
         end
         if (mon_outs != 12'd0 || (exp_pulse.size() > 0 && exp_pulse[0].due <= cyc)) begin
            if (exp_pulse.size() == 0) begin
               check("pulse_unexpected", mon_outs, 12'd0);
            end else begin
               mon_p = exp_pulse.pop_front();
               check("pulse_cycle", cyc, mon_p.due);
               check("pulse_value", mon_outs, expect_out(mon_p.pos));
            end
         end
         if (key_down != prev_kd || (exp_kd.size() > 0 && exp_kd[0].due <= cyc)) begin
            if (exp_kd.size() == 0) begin
               check("kd_unexpected", key_down, prev_kd);
            end else begin
               mon_k = exp_kd.pop_front();
               check("kd_cycle", cyc, mon_k.due);
               check("kd_level", key_down, mon_k.lvl);
            end
         end
         prev_kd    = key_down;
         prev_pulse = (mon_outs != 12'd0);
      end
   end

   initial begin
      #300000;
      $display("FAIL timeout: run did not finish");
      $fatal(1);
   end

   logic [11:0] rm, gm;
   logic [11:0] fm [3];
   int          sel;

   initial begin
      pad_mask[0] = 12'd0; pad_mask[1] = 12'd0; pad_mask[2] = 12'd0;
      model_reset();
      repeat (3) @(negedge clk);
      #2;
      check("rst_col", col, 3'b110);
      check("rst_outs", {key_down, clear, close, tenkey}, 13'd0);
      rst_n = 1'b1;

      // digit 7 (r2/c0) from frame 0: accepted at cycle 24, held, released
      hold(12'h040, 12);
      hold(12'h000, 3);
      // '*' then '#'
      hold(12'h200, 3);
      hold(12'h000, 3);
      hold(12'h800, 3);
      hold(12'h000, 3);
      // keys 1 and 5 together, then key 3 bouncing, then held
      hold(12'h011, 5);
      hold(12'h000, 2);
      repeat (3) begin
         hold(12'h004, 1);
         hold(12'h000, 1);
      end
      hold(12'h004, 2);
      hold(12'h000, 3);
      // roll-over 4 -> 9 without release, then re-press 9
      hold(12'h008, 3);
      hold(12'h100, 4);
      hold(12'h000, 3);
      hold(12'h100, 3);

      // reset mid-frame while 9 is held
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {key_down, clear, close, tenkey}, 13'd0);
      check("mid_rst_col", col, 3'b110);
      model_reset();
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      hold(12'h100, 3);
      hold(12'h000, 3);

      // randomized frames with persistence and occasional in-frame glitches
      rm = 12'd0;
      repeat (80) begin
         sel = $urandom_range(0, 9);
         if (sel < 5)      rm = rm;
         else if (sel < 7) rm = 12'd0;
         else if (sel < 9) rm = 12'h001 << $urandom_range(0, 11);
         else              rm = (12'h001 << $urandom_range(0, 11)) | (12'h001 << $urandom_range(0, 11));
         fm[0] = rm; fm[1] = rm; fm[2] = rm;
         if ($urandom_range(0, 7) == 0) begin
            gm = ($urandom_range(0, 1) == 0) ? 12'd0 : (12'h001 << $urandom_range(0, 11));
            fm[$urandom_range(0, 2)] = gm;
         end
         run_frame(fm[0], fm[1], fm[2]);
      end
      hold(12'h000, 3);

      check("pulse_leftover", exp_pulse.size(), 0);
      check("kd_leftover", exp_kd.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
